// File: rtl/usrt_rx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usrt_rx_ctrl_pkg : register map, bit positions and frame layout            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package usrt_rx_ctrl_pkg;

  localparam logic [2:0] c_ADDR_DATA    = 3'd0;
  localparam logic [2:0] c_ADDR_STATUS  = 3'd1;
  localparam logic [2:0] c_ADDR_CTRL    = 3'd2;
  localparam logic [2:0] c_ADDR_BAUD_LO = 3'd3;
  localparam logic [2:0] c_ADDR_BAUD_HI = 3'd4;

  localparam int c_ST_AVAIL = 0;
  localparam int c_ST_FULL  = 1;
  localparam int c_ST_OVR   = 2;
  localparam int c_ST_PE    = 3;
  localparam int c_ST_FE    = 4;
  localparam int c_ST_RX_EN = 5;

  localparam int c_FRM_START  = 0;
  localparam int c_FRM_DAT_LO = 1;
  localparam int c_FRM_DAT_HI = 8;
  localparam int c_FRM_PAR    = 9;
  localparam int c_FRM_STOP   = 10;

  // Field order mirrors CTRL bits 3:0
  typedef struct packed {
    logic irq_en;
    logic par_odd;
    logic par_en;
    logic rx_en;
  } ctrl_t;

  function automatic logic f_parity_err(input logic [10:0] frame, input ctrl_t ctrl);
    return ctrl.par_en &
           (frame[c_FRM_PAR] != ((^frame[c_FRM_DAT_HI:c_FRM_DAT_LO]) ^ ctrl.par_odd));
  endfunction

endpackage
`default_nettype wire

// File: rtl/usrt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usrt_fifo : synchronous FIFO, push accepted when full if a pop coincides   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module usrt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_Pclk,
  input  logic             i_Rst_n,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic [WIDTH-1:0] i_Din,
  output logic [WIDTH-1:0] o_Dout,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_Full    = (r_count == c_FULL_CNT);
  assign o_Empty   = (r_count == '0);
  assign w_do_pop  = i_Pop & ~o_Empty;
  assign w_do_push = i_Push & (~o_Full | w_do_pop);
  assign o_Dout    = r_mem[r_rptr];

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Power-of-two depth lets pointers wrap by natural overflow
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push & ~w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop & ~w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (w_do_push) r_mem[r_wptr] <= i_Din;
  end

endmodule
`default_nettype wire

// File: rtl/usrt_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usrt_rx_ctrl : USRT receive controller - registers, frame checks, RX FIFO  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module usrt_rx_ctrl
  import usrt_rx_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [13:0] BAUD_RST   = 14'd87
) (
  input  logic        i_Pclk,
  input  logic        i_Rst_n,
  input  logic [2:0]  i_Addr,
  input  logic        i_Wr,
  input  logic        i_Rd,
  input  logic [7:0]  i_Wdata,
  output logic [7:0]  o_Rdata,
  input  logic [10:0] i_Frame,
  input  logic        i_Frame_Done,
  output logic [13:0] o_Baud,
  output logic        o_Rx_En,
  output logic        o_Irq
);

  ctrl_t       r_ctrl;
  logic [13:0] r_baud_shadow;
  logic [13:0] r_baud;
  logic        r_ovr, r_pe, r_fe;
  logic        r_done_d;
  logic        r_irq;
  logic [7:0]  r_rdata;

  logic        w_fifo_full, w_fifo_empty;
  logic [7:0]  w_fifo_dout;
  logic        w_event, w_frame_ok, w_pop, w_push;
  logic        w_set_fe, w_set_pe, w_set_ovr;
  logic [2:0]  w_clr;
  logic [7:0]  w_status;
  logic [7:0]  w_rd_val;

  assign w_event    = i_Frame_Done & ~r_done_d & r_ctrl.rx_en;
  assign w_frame_ok = ~i_Frame[c_FRM_START] & i_Frame[c_FRM_STOP];
  assign w_pop      = i_Rd & (i_Addr == c_ADDR_DATA) & ~w_fifo_empty;
  assign w_push     = w_event & w_frame_ok & (~w_fifo_full | w_pop);
  assign w_set_fe   = w_event & ~w_frame_ok;
  assign w_set_pe   = w_event & w_frame_ok & f_parity_err(i_Frame, r_ctrl);
  assign w_set_ovr  = w_event & w_frame_ok & w_fifo_full & ~w_pop;
  assign w_clr      = (i_Wr && i_Addr == c_ADDR_STATUS) ? i_Wdata[c_ST_FE:c_ST_OVR] : 3'b000;

  assign w_status = {2'b00, r_ctrl.rx_en, r_fe, r_pe, r_ovr, w_fifo_full, ~w_fifo_empty};

  always_comb begin
    w_rd_val = 8'h00;
    case (i_Addr)
      c_ADDR_DATA:    w_rd_val = w_fifo_empty ? 8'h00 : w_fifo_dout;
      c_ADDR_STATUS:  w_rd_val = w_status;
      c_ADDR_CTRL:    w_rd_val = {4'h0, r_ctrl};
      c_ADDR_BAUD_LO: w_rd_val = r_baud_shadow[7:0];
      c_ADDR_BAUD_HI: w_rd_val = {2'b00, r_baud_shadow[13:8]};
      default:        w_rd_val = 8'h00;
    endcase
  end

  usrt_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Pclk  (i_Pclk),
    .i_Rst_n (i_Rst_n),
    .i_Push  (w_push),
    .i_Pop   (w_pop),
    .i_Din   (i_Frame[c_FRM_DAT_HI:c_FRM_DAT_LO]),
    .o_Dout  (w_fifo_dout),
    .o_Full  (w_fifo_full),
    .o_Empty (w_fifo_empty)
  );

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_ctrl        <= '0;
      r_baud_shadow <= BAUD_RST;
      r_baud        <= BAUD_RST;
      r_ovr         <= 1'b0;
      r_pe          <= 1'b0;
      r_fe          <= 1'b0;
      r_done_d      <= 1'b0;
      r_irq         <= 1'b0;
      r_rdata       <= 8'h00;
    end else begin
      r_done_d <= i_Frame_Done;
      if (i_Rd) r_rdata <= w_rd_val;

      if (i_Wr) begin
        case (i_Addr)
          c_ADDR_CTRL:    r_ctrl <= ctrl_t'(i_Wdata[3:0]);
          c_ADDR_BAUD_LO: r_baud_shadow[7:0] <= i_Wdata;
          c_ADDR_BAUD_HI: begin
            r_baud_shadow[13:8] <= i_Wdata[5:0];
            r_baud              <= {i_Wdata[5:0], r_baud_shadow[7:0]};
          end
          default: ;
        endcase
      end

      // A new error in the same cycle as its W1C clear must survive
      r_ovr <= w_set_ovr | (r_ovr & ~w_clr[0]);
      r_pe  <= w_set_pe  | (r_pe  & ~w_clr[1]);
      r_fe  <= w_set_fe  | (r_fe  & ~w_clr[2]);

      r_irq <= r_ctrl.irq_en & (~w_fifo_empty | r_ovr | r_pe | r_fe);
    end
  end

  assign o_Rdata = r_rdata;
  assign o_Baud  = r_baud;
  assign o_Rx_En = r_ctrl.rx_en;
  assign o_Irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_usrt_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usrt_rx_ctrl : register table, directed corner sequences, random mix    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_usrt_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  i_Addr;
  logic        i_Wr, i_Rd;
  logic [7:0]  i_Wdata;
  logic [7:0]  o_Rdata;
  logic [10:0] i_Frame;
  logic        i_Frame_Done;
  logic [13:0] o_Baud;
  logic        o_Rx_En, o_Irq;

  always #5 clk = ~clk;

  usrt_rx_ctrl #(.FIFO_DEPTH(4), .BAUD_RST(14'd87)) dut (
    .i_Pclk(clk), .i_Rst_n(rst_n), .i_Addr(i_Addr), .i_Wr(i_Wr), .i_Rd(i_Rd),
    .i_Wdata(i_Wdata), .o_Rdata(o_Rdata), .i_Frame(i_Frame),
    .i_Frame_Done(i_Frame_Done), .o_Baud(o_Baud), .o_Rx_En(o_Rx_En), .o_Irq(o_Irq)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic [13:0] exp_baud;
  } vec_t;
  vec_t tbl[16];

  // Reference model state
  logic [7:0] m_q[$];
  logic [3:0] m_ctrl;
  bit         m_ovr, m_pe, m_fe;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    i_Addr = a; i_Wdata = d; i_Wr = 1'b1;
    @(posedge clk); #1;
    i_Wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    i_Addr = a; i_Rd = 1'b1;
    @(posedge clk); #1;
    i_Rd = 1'b0;
    d = o_Rdata;
  endtask

  task automatic send(input logic [10:0] f, input int hold);
    @(posedge clk); #1;
    i_Frame = f; i_Frame_Done = 1'b1;
    repeat (hold) @(posedge clk);
    #1 i_Frame_Done = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit odd,
                                           input bit bad_par, input bit bad_start,
                                           input bit bad_stop);
    logic p;
    p = (^d) ^ odd ^ bad_par;
    return {~bad_stop, p, d, bad_start};
  endfunction

  function automatic logic [7:0] m_status();
    return {2'b00, m_ctrl[0], m_fe, m_pe, m_ovr, (m_q.size() == 4), (m_q.size() != 0)};
  endfunction

  task automatic model_frame(input logic [10:0] f);
    int ones;
    if (!m_ctrl[0]) return;
    if (f[0] != 1'b0 || f[10] != 1'b1) begin
      m_fe = 1'b1;
      return;
    end
    ones = $countones(f[8:1]) + (m_ctrl[2] ? 1 : 0);
    if (m_ctrl[1] && (f[9] != ones[0])) m_pe = 1'b1;
    if (m_q.size() < 4) m_q.push_back(f[8:1]);
    else m_ovr = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  d;
    logic [10:0] f;
    rst_n = 1'b0; i_Addr = '0; i_Wr = 0; i_Rd = 0; i_Wdata = '0;
    i_Frame = '0; i_Frame_Done = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset_rdata", o_Rdata, 8'h00);
    chk("reset_baud", o_Baud, 14'd87);
    chk("reset_rx_en", o_Rx_En, 1'b0);
    chk("reset_irq", o_Irq, 1'b0);

    // Register readback and baud commit table
    tbl[0]  = '{1'b0, 3'd2, 8'h00, 8'h00, 14'd87};
    tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00, 14'd87};
    tbl[2]  = '{1'b0, 3'd6, 8'h00, 8'h00, 14'd87};
    tbl[3]  = '{1'b1, 3'd3, 8'h57, 8'h00, 14'd87};
    tbl[4]  = '{1'b1, 3'd4, 8'h00, 8'h00, 14'd87};
    tbl[5]  = '{1'b1, 3'd3, 8'h10, 8'h00, 14'd87};
    tbl[6]  = '{1'b0, 3'd3, 8'h00, 8'h10, 14'd87};
    tbl[7]  = '{1'b1, 3'd4, 8'h01, 8'h00, 14'h0110};
    tbl[8]  = '{1'b0, 3'd4, 8'h00, 8'h01, 14'h0110};
    tbl[9]  = '{1'b1, 3'd5, 8'hFF, 8'h00, 14'h0110};
    tbl[10] = '{1'b0, 3'd5, 8'h00, 8'h00, 14'h0110};
    tbl[11] = '{1'b1, 3'd4, 8'hFF, 8'h00, 14'h3F10};
    tbl[12] = '{1'b0, 3'd4, 8'h00, 8'h3F, 14'h3F10};
    tbl[13] = '{1'b1, 3'd2, 8'hFA, 8'h00, 14'h3F10};
    tbl[14] = '{1'b0, 3'd2, 8'h00, 8'h0A, 14'h3F10};
    tbl[15] = '{1'b1, 3'd2, 8'h00, 8'h00, 14'h3F10};
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
      else begin
        rd(tbl[i].addr, d);
        chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rd);
      end
      chk($sformatf("tbl%0d_baud", i), o_Baud, tbl[i].exp_baud);
    end

    // Good frame with interrupt timing
    wr(3'd2, 8'h0B);
    chk("good_irq_idle", o_Irq, 1'b0);
    @(posedge clk); #1;
    i_Frame = 11'b10100011010; i_Frame_Done = 1'b1;
    @(posedge clk); #1;
    i_Frame_Done = 1'b0;
    chk("good_irq_push_cycle", o_Irq, 1'b0);
    @(posedge clk); #1;
    chk("good_irq_after_push", o_Irq, 1'b1);
    rd(3'd1, d); chk("good_status", d, 8'h21);
    rd(3'd0, d); chk("good_data", d, 8'h8D);
    @(posedge clk); #1;
    chk("good_irq_after_pop", o_Irq, 1'b0);
    rd(3'd1, d); chk("good_status_empty", d, 8'h20);

    // Parity error still queues the byte
    wr(3'd2, 8'h07);
    send(11'b10100011010, 1);
    rd(3'd1, d); chk("pe_status", d, 8'h29);
    wr(3'd1, 8'h08);
    rd(3'd1, d); chk("pe_cleared", d, 8'h21);
    rd(3'd0, d); chk("pe_data", d, 8'h8D);

    // Framing error discards
    wr(3'd2, 8'h03);
    send(11'b00100011010, 1);
    rd(3'd1, d); chk("fe_status", d, 8'h30);
    rd(3'd0, d); chk("fe_data_empty", d, 8'h00);
    wr(3'd1, 8'h10);

    // Overrun
    for (int i = 1; i <= 5; i++) send(mk_frame(8'(i * 17), 1'b0, 0, 0, 0), 1);
    rd(3'd1, d); chk("ovr_status", d, 8'h27);
    for (int i = 1; i <= 4; i++) begin
      rd(3'd0, d); chk($sformatf("ovr_data%0d", i), d, 8'(i * 17));
    end
    wr(3'd1, 8'h04);
    for (int i = 1; i <= 4; i++) send(mk_frame(8'(i + 8'hA0), 1'b0, 0, 0, 0), 1);
    @(posedge clk); #1;
    i_Addr = 3'd0; i_Rd = 1'b1;
    i_Frame = mk_frame(8'hC5, 1'b0, 0, 0, 0); i_Frame_Done = 1'b1;
    @(posedge clk); #1;
    i_Rd = 1'b0; i_Frame_Done = 1'b0;
    chk("pushpop_rdata", o_Rdata, 8'hA1);
    rd(3'd1, d); chk("pushpop_status", d, 8'h23);
    for (int i = 2; i <= 4; i++) begin
      rd(3'd0, d); chk($sformatf("pushpop_data%0d", i), d, 8'(i + 8'hA0));
    end
    rd(3'd0, d); chk("pushpop_new", d, 8'hC5);
    rd(3'd1, d); chk("pushpop_drained", d, 8'h20);

    // Held done produces a single push
    send(mk_frame(8'h3C, 1'b0, 0, 0, 0), 20);
    rd(3'd1, d); chk("held_status", d, 8'h21);
    rd(3'd0, d); chk("held_data", d, 8'h3C);
    rd(3'd1, d); chk("held_single", d, 8'h20);

    // Disabled receiver ignores frames
    wr(3'd2, 8'h00);
    send(mk_frame(8'h66, 1'b0, 0, 0, 0), 1);
    send(mk_frame(8'h66, 1'b0, 0, 0, 1), 1);
    rd(3'd1, d); chk("disabled_status", d, 8'h00);

    // Reset with data queued, done held through release
    wr(3'd2, 8'h09);
    send(mk_frame(8'h12, 1'b0, 0, 0, 0), 1);
    send(mk_frame(8'h34, 1'b0, 0, 0, 0), 1);
    rd(3'd1, d); chk("prereset_status", d, 8'h21);
    @(posedge clk); #1;
    i_Frame = mk_frame(8'h56, 1'b0, 0, 0, 0); i_Frame_Done = 1'b1;
    rst_n = 1'b0;
    #1 chk("reset_async_irq", o_Irq, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_Frame_Done = 1'b0;
    rd(3'd1, d); chk("postreset_status", d, 8'h00);
    rd(3'd0, d); chk("postreset_data", d, 8'h00);
    chk("postreset_baud", o_Baud, 14'd87);

    // Randomized traffic against the queue model
    m_q.delete(); m_ovr = 0; m_pe = 0; m_fe = 0;
    m_ctrl = 4'hB;
    wr(3'd2, {4'h0, m_ctrl});
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) begin
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 4) != 0) c[0] = 1'b1;
        wr(3'd2, {4'h0, c});
        m_ctrl = c;
      end else if (r < 45) begin
        f = mk_frame(8'($urandom), m_ctrl[2], ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        send(f, $urandom_range(1, 3));
        model_frame(f);
      end else if (r < 70) begin
        logic [7:0] e;
        rd(3'd0, d);
        e = (m_q.size() != 0) ? m_q.pop_front() : 8'h00;
        chk("rnd_data", d, e);
      end else if (r < 85) begin
        rd(3'd1, d);
        chk("rnd_status", d, m_status());
      end else begin
        logic [7:0] w;
        w = 8'($urandom);
        wr(3'd1, w);
        if (w[2]) m_ovr = 1'b0;
        if (w[3]) m_pe  = 1'b0;
        if (w[4]) m_fe  = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd_irq", o_Irq, m_ctrl[3] & ((m_q.size() != 0) | m_ovr | m_pe | m_fe));
      chk("rnd_rx_en", o_Rx_En, m_ctrl[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usrt_rx_ctrl.md
Name: usrt_rx_ctrl

Overview:
Register-mapped controller that configures and sequences the USRT receive path. It holds the baud divisor and enable fed to baudgen, and consumes 11-bit frames from rxshift. Each frame is checked for framing and parity, and good data bytes are queued in a small FIFO. A simple 8-bit host register bus reads the data, status and error flags, and an interrupt line reports pending data or errors.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries (power of two, minimum 2)
BAUD_RST, 87, reset value of baud divisor (Pclk cycles per Bclk half-period)

Ports:
i_Pclk  in  1  system clock; all logic on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Addr  in  3  register address
i_Wr  in  1  write strobe, one cycle
i_Rd  in  1  read strobe, one cycle
i_Wdata  in  8  write data
o_Rdata  out  8  registered read data
i_Frame  in  11  frame from rxshift o_Data; bit0 = start, bits8:1 = data LSB first, bit9 = parity, bit10 = stop
i_Frame_Done  in  1  rxshift o_Done (level; may stay high for multiple Pclk cycles)
o_Baud  out  14  divisor to baudgen i_Baud
o_Rx_En  out  1  receive enable
o_Irq  out  1  interrupt, level

Behaviour:
- Reset values: o_Rdata=0, o_Baud=BAUD_RST, o_Rx_En=0, o_Irq=0, FIFO empty, all sticky flags 0, CTRL=0, baud shadow=BAUD_RST.
- Register map:
  - 0 DATA (R): read pops the FIFO head.
  - 1 STATUS:
    - R: bit0 AVAIL, bit1 FULL, bit2 OVR, bit3 PE, bit4 FE, bit5 RX_EN, others 0.
    - W: write-1-to-clear on bits 4:2.
  - 2 CTRL (R/W): bit0 RX_EN, bit1 PAR_EN, bit2 PAR_ODD, bit3 IRQ_EN.
  - 3 BAUD_LO (R/W shadow bits 7:0).
  - 4 BAUD_HI (R/W shadow bits 13:8). Writing BAUD_HI commits the full shadow to o_Baud on the next cycle.
  - Addresses 5-7: read 0, writes ignored.
- Read timing:
  - o_Rdata updates the cycle after i_Rd and holds until the next read.
  - DATA read with the FIFO empty returns 0x00 and does not pop.
- Frame event: rising edge of i_Frame_Done, via an internal registered edge detector. Exactly one event per high period. The check runs in the event cycle.
- Event handling when RX_EN=0: no action.
- Framing check: i_Frame[0]!=0 or i_Frame[10]!=1 sets FE and discards the byte.
- Parity check (PAR_EN=1):
  - Expected parity bit = XOR(data) XOR PAR_ODD.
  - A mismatch sets PE, but the byte is still pushed.
- PAR_EN=0: bit9 is ignored.
- Push and overrun:
  - Push when the frame passes framing and the FIFO is not full.
  - FIFO full with no pop in the same cycle: byte dropped, OVR set.
  - Push and pop in the same cycle when full: both occur, no OVR, occupancy unchanged.
- Sticky clear vs. new set:
  - A W1C clear and a new set of the same flag in the same cycle: the set wins.
- Clearing RX_EN:
  - Stops further pushes.
  - FIFO contents are retained.
- o_Irq = IRQ_EN & (AVAIL | OVR | PE | FE), registered (one-cycle latency).
- Baud changes mid-frame are the host's responsibility; the controller does not gate the commit.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Async reset mid-frame discards the FIFO and flags. The edge detector resets to 0, so an i_Frame_Done held high through reset release is not counted.

Decomposition:
- Shared include usrt_defs.vh: register addresses, STATUS/CTRL bit positions, frame bit indices (start=0, data 8:1, parity=9, stop=10).
- One sub-module usrt_fifo: synchronous FIFO, parameters width 8 and depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-low reset on i_Rst_n.

Test Plan:
- Reset/readback: read CTRL=0x00 and STATUS=0x00. Write BAUD_LO=0x57, BAUD_HI=0x00 → o_Baud=87. Write BAUD_LO=0x10 then BAUD_HI=0x01 → o_Baud=0x110 only after the BAUD_HI write.
- Good frame: CTRL=0x03 (RX_EN, even parity), frame 11'b10100011010 → AVAIL=1, DATA read=0x8D, then AVAIL=0 and PE=0. With IRQ_EN set, o_Irq rises one cycle after the push and falls after the pop.
- Parity error: PAR_ODD=1, same frame → PE=1 and byte 0x8D still queued. STATUS write 0x08 clears PE.
- Framing error: frame 11'b00100011010 (stop=0) → FE=1, FIFO stays empty, DATA read returns 0x00.
- Overrun: push 5 valid frames with FIFO_DEPTH=4 → FULL=1, OVR=1. Four reads return the first 4 bytes in order. Push coincident with a pop while full → no OVR.
- Held done/disable: i_Frame_Done held high for 20 cycles → exactly one push. RX_EN=0 with a frame → no push and no flags. Reset asserted with 2 bytes queued → STATUS=0x00.
